// File: rtl/neosd_card_cmd_fsm.sv
// neosd_card_cmd_fsm: card-side SD CMD line engine.
// Receives 48-bit host command frames, checks framing and CRC7, presents {idx,arg} to card logic,
// and then transmits an R1/R2/R3-style response after the Ncr gap. Each clkstrb_i pulse is one SD bit slot.
// Ports:
//   clk_i, rstn_i            system clock, synchronous active-low reset
//   clkstrb_i                SD bit strobe; CMD line sampled/driven only when high
//   sd_cmd_i                 CMD line in
//   sd_cmd_o, sd_cmd_oe      CMD line out / output enable (sd_cmd_o is 1 whenever oe is 0)
//   cmd_valid_o              received command valid, held until a response is accepted
//   cmd_idx_o, cmd_arg_o     received command index / argument
//   cmd_err_o                one-clock pulse when a received frame is dropped
//   resp_valid_i             response available (accepted only while a command is presented)
//   resp_mode_i              0 none, 1 R1, 2 R2, 3 R3
//   resp_idx_i               index field of a 48-bit response
//   resp_data_i              short: [31:0] argument; R2: [127:1] sent verbatim
//   idle_o                   engine is idle
module neosd_card_cmd_fsm #(
    parameter int unsigned NCR = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clkstrb_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    output logic         cmd_err_o,
    input  logic         resp_valid_i,
    input  logic [1:0]   resp_mode_i,
    input  logic [5:0]   resp_idx_i,
    input  logic [127:0] resp_data_i,
    output logic         idle_o
);

    localparam int unsigned TX_W      = 136;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned NCR_W     = 7;
    localparam int unsigned NCR_MAX   = 64;
    localparam int unsigned SHORT_TOP = 47;
    localparam int unsigned LONG_TOP  = 135;

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_CHECK, S_PRESENT, S_WAIT_NCR, S_TX
    } state_t;

    state_t            state;
    logic [46:0]       rx_sr;
    logic [6:0]        crc;
    logic [CNT_W-1:0]  bit_cnt;
    logic [NCR_W-1:0]  ncr_cnt;
    logic [TX_W-1:0]   tx_sr;
    logic              crc_gen;
    logic              tx_long;

    logic [CNT_W-1:0]  tx_idx_c;
    logic              in_crc_c;
    logic              tx_bit_c;

    // One step of the CRC7 LFSR (x^7 + x^3 + 1)
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Next transmit bit: R1 drives the running CRC in the CRC field slots
    assign tx_idx_c = bit_cnt - CNT_W'(1);
    assign in_crc_c = crc_gen && (tx_idx_c >= CNT_W'(1)) && (tx_idx_c <= CNT_W'(7));
    assign tx_bit_c = in_crc_c ? crc[6] : tx_sr[TX_W-1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            rx_sr       <= '0;
            crc         <= '0;
            bit_cnt     <= '0;
            ncr_cnt     <= '0;
            tx_sr       <= '0;
            crc_gen     <= 1'b0;
            tx_long     <= 1'b0;
            sd_cmd_o    <= 1'b1;
            sd_cmd_oe   <= 1'b0;
            cmd_valid_o <= 1'b0;
            cmd_idx_o   <= '0;
            cmd_arg_o   <= '0;
            cmd_err_o   <= 1'b0;
            idle_o      <= 1'b1;
        end else begin
            cmd_err_o <= 1'b0;
            case (state)
                // Start bit (bit 47) is 0, so clearing the CRC is equivalent to feeding it
                S_IDLE: begin
                    if (clkstrb_i && !sd_cmd_i) begin
                        state   <= S_RX;
                        bit_cnt <= CNT_W'(46);
                        crc     <= '0;
                        idle_o  <= 1'b0;
                    end
                end
                S_RX: begin
                    if (clkstrb_i) begin
                        rx_sr <= {rx_sr[45:0], sd_cmd_i};
                        if (bit_cnt >= CNT_W'(8)) begin
                            crc <= crc7_step(crc, sd_cmd_i);
                        end
                        if (bit_cnt == '0) begin
                            state <= S_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                // Bad frames are silently dropped apart from the error pulse
                S_CHECK: begin
                    if (rx_sr[46] && rx_sr[0] && (crc == rx_sr[7:1])) begin
                        cmd_idx_o   <= rx_sr[45:40];
                        cmd_arg_o   <= rx_sr[39:8];
                        cmd_valid_o <= 1'b1;
                        ncr_cnt     <= NCR_W'(1);
                        state       <= S_PRESENT;
                    end else begin
                        cmd_err_o <= 1'b1;
                        idle_o    <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_PRESENT: begin
                    if (clkstrb_i && (ncr_cnt < NCR_W'(NCR_MAX))) begin
                        ncr_cnt <= ncr_cnt + NCR_W'(1);
                    end
                    if (resp_valid_i) begin
                        cmd_valid_o <= 1'b0;
                        if (resp_mode_i == 2'd0) begin
                            idle_o <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            crc_gen <= (resp_mode_i == 2'd1);
                            tx_long <= (resp_mode_i == 2'd2);
                            if (resp_mode_i == 2'd2) begin
                                tx_sr <= {2'b00, 6'h3F, resp_data_i[127:1], 1'b1};
                            end else begin
                                tx_sr <= {2'b00, resp_idx_i, resp_data_i[31:0], 7'h7F, 1'b1, 88'h0};
                            end
                            state <= S_WAIT_NCR;
                        end
                    end
                end
                // Ncr counter keeps running here; a late response leaves no extra gap
                S_WAIT_NCR: begin
                    if (clkstrb_i) begin
                        if (ncr_cnt >= NCR_W'(NCR)) begin
                            sd_cmd_oe <= 1'b1;
                            sd_cmd_o  <= tx_sr[TX_W-1];
                            tx_sr     <= {tx_sr[TX_W-2:0], 1'b0};
                            bit_cnt   <= tx_long ? CNT_W'(LONG_TOP) : CNT_W'(SHORT_TOP);
                            crc       <= '0;
                            state     <= S_TX;
                        end else if (ncr_cnt < NCR_W'(NCR_MAX)) begin
                            ncr_cnt <= ncr_cnt + NCR_W'(1);
                        end
                    end
                end
                // bit_cnt holds the index of the bit currently on the line
                S_TX: begin
                    if (clkstrb_i) begin
                        if (bit_cnt == '0) begin
                            sd_cmd_oe <= 1'b0;
                            sd_cmd_o  <= 1'b1;
                            idle_o    <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            sd_cmd_o <= tx_bit_c;
                            tx_sr    <= {tx_sr[TX_W-2:0], 1'b0};
                            bit_cnt  <= tx_idx_c;
                            if (in_crc_c) begin
                                crc <= {crc[5:0], 1'b0};
                            end else if (crc_gen && (tx_idx_c >= CNT_W'(8))) begin
                                crc <= crc7_step(crc, tx_bit_c);
                            end
                        end
                    end
                end
                default: begin
                    idle_o <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neosd_card_cmd_fsm.sv
// tb_neosd_card_cmd_fsm: drives host command frames bit-slot by bit-slot, answers them with responses,
// and compares the CMD line against frames built from the SD framing rules.
module tb_neosd_card_cmd_fsm;

    localparam int unsigned NCR = 2;

    logic         clk = 1'b0;
    logic         rstn_i = 1'b0;
    logic         clkstrb_i = 1'b0;
    logic         sd_cmd_i = 1'b1;
    logic         sd_cmd_o;
    logic         sd_cmd_oe;
    logic         cmd_valid_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         cmd_err_o;
    logic         resp_valid_i = 1'b0;
    logic [1:0]   resp_mode_i = 2'd0;
    logic [5:0]   resp_idx_i = 6'd0;
    logic [127:0] resp_data_i = '0;
    logic         idle_o;

    always #5 clk = ~clk;

    neosd_card_cmd_fsm #(.NCR(NCR)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .clkstrb_i(clkstrb_i), .sd_cmd_i(sd_cmd_i),
        .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .cmd_valid_o(cmd_valid_o),
        .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o), .cmd_err_o(cmd_err_o),
        .resp_valid_i(resp_valid_i), .resp_mode_i(resp_mode_i), .resp_idx_i(resp_idx_i),
        .resp_data_i(resp_data_i), .idle_o(idle_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int valid_rises = 0;
    logic valid_q = 1'b0;

    // Event counters sampled on the inactive edge
    always @(negedge clk) begin
        if (cmd_err_o) err_cnt++;
        if (cmd_valid_o && !valid_q) valid_rises++;
        valid_q = cmd_valid_o;
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as remainder of polynomial division by x^7+x^3+1
    function automatic logic [6:0] crc7_of(input logic [39:0] v);
        logic [46:0] m;
        m = {v, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] v;
        v = {2'b01, idx, arg};
        return {v, crc7_of(v), 1'b1};
    endfunction

    // Expected response bits right-aligned, plus length in bits
    function automatic logic [135:0] exp_resp(input logic [1:0] mode, input logic [5:0] idx,
                                              input logic [127:0] data, output int len);
        logic [39:0] v;
        v = {2'b00, idx, data[31:0]};
        len = (mode == 2'd2) ? 136 : 48;
        if (mode == 2'd2) return {2'b00, 6'h3F, data[127:1], 1'b1};
        if (mode == 2'd1) return 136'({v, crc7_of(v), 1'b1});
        return 136'({v, 7'h7F, 1'b1});
    endfunction

    // One SD bit slot: strobe for one clock, then two quiet clocks
    task automatic slot(input logic b, output logic oe, output logic o);
        @(negedge clk);
        resp_valid_i = 1'b0;
        sd_cmd_i = b;
        clkstrb_i = 1'b1;
        @(negedge clk);
        clkstrb_i = 1'b0;
        oe = sd_cmd_oe;
        o  = sd_cmd_o;
        @(negedge clk);
    endtask

    task automatic idle_slots(input int n, output int oe_high);
        logic oe, o;
        oe_high = 0;
        for (int i = 0; i < n; i++) begin
            slot(1'b1, oe, o);
            if (oe) oe_high++;
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        logic oe, o;
        for (int i = 47; i >= 0; i--) slot(f[i], oe, o);
    endtask

    // Delay k strobes, hand over the response, then capture the CMD line
    task automatic respond(input string tag, input logic [1:0] mode, input logic [5:0] idx,
                           input logic [127:0] data, input int k,
                           output logic [135:0] got, output int n, output int gap);
        logic oe, o;
        int   oe_high, bad_idle, exp_len, exp_gap, c;
        logic [135:0] exp;
        got = '0; n = 0; gap = 0; bad_idle = 0;
        idle_slots(k, oe_high);
        check({tag, "_valid_held"}, 136'(cmd_valid_o), 136'(1));
        resp_valid_i = 1'b1;
        resp_mode_i  = mode;
        resp_idx_i   = idx;
        resp_data_i  = data;
        if (mode == 2'd0) begin
            @(negedge clk);
            resp_valid_i = 1'b0;
            check({tag, "_valid_drop"}, 136'(cmd_valid_o), 136'(0));
            check({tag, "_idle"}, 136'(idle_o), 136'(1));
            idle_slots(60, oe_high);
            check({tag, "_oe_never"}, 136'(oe_high), 136'(0));
            return;
        end
        for (int s = 0; s < 400; s++) begin
            slot(1'b1, oe, o);
            if (!oe && o !== 1'b1) bad_idle++;
            if (oe) begin
                got = {got[134:0], o};
                n++;
            end else if (n == 0) begin
                gap++;
            end else begin
                break;
            end
        end
        c = (1 + k > 64) ? 64 : 1 + k;
        exp_gap = (int'(NCR) > c) ? int'(NCR) - c : 0;
        exp = exp_resp(mode, idx, data, exp_len);
        check({tag, "_gap"}, 136'(gap), 136'(exp_gap));
        check({tag, "_len"}, 136'(n), 136'(exp_len));
        check({tag, "_bits"}, got, exp);
        check({tag, "_idle_line"}, 136'(bad_idle), 136'(0));
        check({tag, "_valid_after"}, 136'(cmd_valid_o), 136'(0));
        check({tag, "_idle_end"}, 136'(idle_o), 136'(1));
    endtask

    task automatic expect_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                              input int err0);
        check({tag, "_valid"}, 136'(cmd_valid_o), 136'(1));
        check({tag, "_idx"}, 136'(cmd_idx_o), 136'(idx));
        check({tag, "_arg"}, 136'(cmd_arg_o), 136'(arg));
        check({tag, "_noerr"}, 136'(err_cnt - err0), 136'(0));
    endtask

    initial begin
        logic [135:0] got;
        int n, gap, e0, v0, oe_high, len;
        logic [47:0] f;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  mode;
        logic [127:0] data;
        logic oe, o;

        repeat (3) @(negedge clk);
        check("rst_oe", 136'(sd_cmd_oe), 136'(0));
        check("rst_cmd_o", 136'(sd_cmd_o), 136'(1));
        check("rst_valid", 136'(cmd_valid_o), 136'(0));
        check("rst_err", 136'(cmd_err_o), 136'(0));
        check("rst_idle", 136'(idle_o), 136'(1));
        check("rst_idx_arg", 136'({cmd_idx_o, cmd_arg_o}), 136'(0));
        rstn_i = 1'b1;
        idle_slots(4, oe_high);

        // CMD0, no response
        e0 = err_cnt;
        send_frame(48'h40_0000_0000_95);
        expect_cmd("cmd0", 6'd0, 32'd0, e0);
        respond("cmd0", 2'd0, 6'd0, '0, 0, got, n, gap);

        // CMD8 with R1
        e0 = err_cnt;
        send_frame(48'h48_0000_01AA_87);
        expect_cmd("cmd8", 6'd8, 32'h1AA, e0);
        respond("cmd8", 2'd1, 6'd8, 128'h1AA, 0, got, n, gap);
        check("cmd8_r1_literal", got, 136'(48'h08_0000_01AA_13));
        check("cmd8_gap_literal", 136'(gap), 136'(1));
        idle_slots(3, oe_high);

        // CMD8 with corrupted CRC, then a good frame
        e0 = err_cnt; v0 = valid_rises;
        send_frame(48'h48_0000_01AA_85);
        idle_slots(20, oe_high);
        check("badcrc_err", 136'(err_cnt - e0), 136'(1));
        check("badcrc_novalid", 136'(valid_rises - v0), 136'(0));
        check("badcrc_oe", 136'(oe_high), 136'(0));
        check("badcrc_idle", 136'(idle_o), 136'(1));
        e0 = err_cnt;
        send_frame(48'h48_0000_01AA_87);
        expect_cmd("after_bad", 6'd8, 32'h1AA, e0);

        // R2 payload
        respond("r2", 2'd2, 6'd2, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 0, got, n, gap);
        idle_slots(2, oe_high);

        // Late R3 response
        e0 = err_cnt;
        send_frame(make_frame(6'd41, 32'h00FF_8000));
        expect_cmd("acmd41", 6'd41, 32'h00FF_8000, e0);
        respond("r3_late", 2'd3, 6'h3F, 128'h80FF_8000, 20, got, n, gap);
        check("r3_crc_field", 136'(got[7:1]), 136'(7'h7F));

        // Randomised good frames with random response types and delays
        for (int it = 0; it < 8; it++) begin
            idx  = 6'($urandom_range(0, 63));
            arg  = $urandom;
            mode = 2'($urandom_range(0, 3));
            data = {$urandom, $urandom, $urandom, $urandom};
            e0 = err_cnt;
            send_frame(make_frame(idx, arg));
            expect_cmd($sformatf("rnd%0d", it), idx, arg, e0);
            respond($sformatf("rnd%0d", it), mode, 6'($urandom_range(0, 63)), data,
                    int'($urandom_range(0, 70)), got, n, gap);
            idle_slots(int'($urandom_range(1, 4)), oe_high);
        end

        // Randomised single-bit corruption (any bit after the start bit)
        for (int it = 0; it < 4; it++) begin
            f = make_frame(6'($urandom_range(0, 63)), $urandom);
            n = int'($urandom_range(0, 46));
            f[n] = ~f[n];
            e0 = err_cnt; v0 = valid_rises;
            send_frame(f);
            idle_slots(10, oe_high);
            check($sformatf("flip%0d_err", it), 136'(err_cnt - e0), 136'(1));
            check($sformatf("flip%0d_novalid", it), 136'(valid_rises - v0), 136'(0));
            check($sformatf("flip%0d_oe", it), 136'(oe_high), 136'(0));
        end

        // Reset in the middle of a response
        send_frame(make_frame(6'd2, 32'd0));
        resp_valid_i = 1'b1;
        resp_mode_i  = 2'd2;
        resp_data_i  = {4{$urandom}};
        n = 0;
        for (int s = 0; s < 60 && n < 21; s++) begin
            slot(1'b1, oe, o);
            if (oe) n++;
        end
        check("rstmid_reached", 136'(n), 136'(21));
        rstn_i = 1'b0;
        @(negedge clk);
        check("rstmid_oe", 136'(sd_cmd_oe), 136'(0));
        check("rstmid_cmd_o", 136'(sd_cmd_o), 136'(1));
        check("rstmid_idle", 136'(idle_o), 136'(1));
        check("rstmid_valid", 136'(cmd_valid_o), 136'(0));
        rstn_i = 1'b1;
        idle_slots(3, oe_high);
        check("rstmid_quiet", 136'(oe_high), 136'(0));
        e0 = err_cnt;
        send_frame(48'h40_0000_0000_95);
        expect_cmd("post_rst", 6'd0, 32'd0, e0);
        respond("post_rst", 2'd1, 6'd0, 128'h0000_0120, 3, got, n, gap);
        len = 0;
        check("post_rst_model", got, exp_resp(2'd1, 6'd0, 128'h0000_0120, len));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
